// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/RF pipeline register, applying load-use stalls and decode redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic             if_valid,
    output logic [CNT_W-1:0] squash_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Redirects only count when decode holds a real instruction; a bubble's inputs are stale.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        redirect = 1'b0;
        next_pc  = pc_plus4;
        if (if_valid) begin
            if (jr) begin
                redirect = 1'b1;
                next_pc  = {jr_target[31:2], 2'b00};
            end else if (branch_taken) begin
                redirect = 1'b1;
                next_pc  = {branch_target[31:2], 2'b00};
            end else if (jump) begin
                redirect = 1'b1;
                next_pc  = {if_pc_plus4[31:28], jump_index, 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc           <= RESET_PC;
            if_instr     <= '0;
            if_pc        <= '0;
            if_pc_plus4  <= '0;
            if_valid     <= 1'b0;
            squash_count <= '0;
        end else if (!stall) begin
            pc <= next_pc;
            if (redirect) begin
                // No delay slot: the word fetched this cycle is discarded.
                if_instr    <= '0;
                if_pc       <= '0;
                if_pc_plus4 <= '0;
                if_valid    <= 1'b0;
                if (squash_count != '1) begin
                    squash_count <= squash_count + CNT_ONE;
                end
            end else begin
                if_instr    <= imem_data;
                if_pc       <= pc;
                if_pc_plus4 <= pc_plus4;
                if_valid    <= 1'b1;
            end
        end
    end

endmodule
